// File: rtl/imem_bus_ctrl.sv
// Instruction-memory bus slave: owns the instruction RAM and shares its single
// port between the CPU fetch stage and the program loader. Fetch reads return
// after a fixed latency. Arbitration alternates between the two sides on ties.
module imem_bus_ctrl #(
  parameter int ADR_W  = 12,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_read_req,
  input  logic             i_read_w,
  input  logic             i_read_hw,
  input  logic [31:0]      i_read_adr,
  output logic             i_read_valid,
  output logic [31:0]      i_read_data,
  output logic             i_read_err,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [31:0]      ld_wdata,
  output logic             ld_ack,
  output logic             ld_rvalid,
  output logic [31:0]      ld_rdata,
  output logic             ovr_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, FRD = 2'd1, LWR = 2'd2, LRD = 2'd3} state_e;

  localparam logic [2:0] LAT   = 3'(RD_LAT);
  localparam int         DEPTH = 1 << ADR_W;

  // A fetch is illegal when it is outside the RAM, misaligned, or not a word access.
  function automatic logic fetch_err(input logic [31:0] adr, input logic w, input logic hw);
    fetch_err = ((adr >> (ADR_W + 2)) != 32'd0) || (adr[1:0] != 2'b00) || !w || hw;
  endfunction

  logic [31:0]      mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             fp_q, fp_d;             // fetch waiting for a slot
  logic [ADR_W-1:0] fadr_q, fadr_d;
  logic             ferr_q, ferr_d;
  logic             last_fetch_q, last_fetch_d; // 1: fetch won the last arbitration
  logic [ADR_W-1:0] cur_adr_q;
  logic             cur_err_q;
  logic             ovr_q;
  logic             i_read_valid_q, i_read_err_q, ld_rvalid_q;
  logic [31:0]      i_read_data_q, ld_rdata_q;

  logic             ovr_s, new_f_s, f_cand_s, f_win_s, l_win_s, f_err_s;
  logic [ADR_W-1:0] f_adr_s, ram_adr_s;
  logic             ram_we_s, op_err_s, f_done_s, l_done_s;

  // Arbitration: a new fetch is dropped if one is already pending or in flight.
  assign ovr_s    = i_read_req && (fp_q || (state_q == FRD));
  assign new_f_s  = i_read_req && !ovr_s;
  assign f_cand_s = fp_q || new_f_s;
  assign f_adr_s  = fp_q ? fadr_q : i_read_adr[ADR_W+1:2];
  assign f_err_s  = fp_q ? ferr_q : fetch_err(i_read_adr, i_read_w, i_read_hw);
  assign f_win_s  = (state_q == IDLE) && f_cand_s && (!ld_req || !last_fetch_q);
  assign l_win_s  = (state_q == IDLE) && ld_req && (!f_cand_s || last_fetch_q);

  assign ld_ack       = l_win_s;
  assign i_read_valid = i_read_valid_q;
  assign i_read_data  = i_read_data_q;
  assign i_read_err   = i_read_err_q;
  assign ld_rvalid    = ld_rvalid_q;
  assign ld_rdata     = ld_rdata_q;
  assign ovr_err      = ovr_q;

  // Pending-fetch capture and last-winner bookkeeping.
  always_comb begin
    fp_d         = fp_q;
    fadr_d       = fadr_q;
    ferr_d       = ferr_q;
    last_fetch_d = last_fetch_q;
    if (f_win_s) begin
      fp_d         = 1'b0;
      last_fetch_d = 1'b1;
    end else if (new_f_s) begin
      fp_d   = 1'b1;
      fadr_d = i_read_adr[ADR_W+1:2];
      ferr_d = fetch_err(i_read_adr, i_read_w, i_read_hw);
      if (l_win_s) begin
        last_fetch_d = 1'b0;
      end else begin
        last_fetch_d = last_fetch_q;
      end
    end else if (l_win_s) begin
      last_fetch_d = 1'b0;
    end else begin
      last_fetch_d = last_fetch_q;
    end
  end

  // FSM next state: read states count 1..RD_LAT, loader write takes one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (f_win_s) begin
          state_d = FRD;
          cnt_d   = 3'd1;
        end else if (l_win_s && ld_we) begin
          state_d = LWR;
          cnt_d   = 3'd1;
        end else if (l_win_s) begin
          state_d = LRD;
          cnt_d   = 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      FRD, LRD: begin
        if (cnt_q == LAT) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      LWR: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // FSM outputs: RAM port address/enable and completion strobes for the next cycle.
  always_comb begin
    ram_we_s  = l_win_s && ld_we;
    ram_adr_s = cur_adr_q;
    op_err_s  = cur_err_q;
    if (state_q == IDLE) begin
      if (f_win_s) begin
        ram_adr_s = f_adr_s;
        op_err_s  = f_err_s;
      end else begin
        ram_adr_s = ld_adr;
        op_err_s  = 1'b0;
      end
    end else begin
      ram_adr_s = cur_adr_q;
      op_err_s  = cur_err_q;
    end
    f_done_s = (state_d == FRD) && (cnt_d == LAT);
    l_done_s = (state_d == LRD) && (cnt_d == LAT);
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ld_adr] <= ld_wdata;
    end
  end

  // State register, pending fetch, sticky overrun and registered read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      fp_q           <= 1'b0;
      fadr_q         <= '0;
      ferr_q         <= 1'b0;
      last_fetch_q   <= 1'b0;
      cur_adr_q      <= '0;
      cur_err_q      <= 1'b0;
      ovr_q          <= 1'b0;
      i_read_valid_q <= 1'b0;
      i_read_data_q  <= 32'h0;
      i_read_err_q   <= 1'b0;
      ld_rvalid_q    <= 1'b0;
      ld_rdata_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fp_q         <= fp_d;
      fadr_q       <= fadr_d;
      ferr_q       <= ferr_d;
      last_fetch_q <= last_fetch_d;
      if (state_q == IDLE) begin
        cur_adr_q <= ram_adr_s;
        cur_err_q <= op_err_s;
      end
      ovr_q          <= ovr_q | ovr_s;
      i_read_valid_q <= f_done_s;
      i_read_err_q   <= f_done_s && op_err_s;
      if (f_done_s) begin
        i_read_data_q <= op_err_s ? 32'h0 : mem_q[ram_adr_s];
      end
      ld_rvalid_q <= l_done_s;
      if (l_done_s) begin
        ld_rdata_q <= mem_q[ram_adr_s];
      end
    end
  end

endmodule

// File: tb/tb_imem_bus_ctrl.sv
// Bench for imem_bus_ctrl: directed scenarios on an RD_LAT=2 instance plus
// randomized fetches checked on RD_LAT=1, 2 and 4 instances against a model.
module tb_imem_bus_ctrl;

  localparam int LAT_M = 2;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] d;
    logic        e;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic        ld_req, ld_we;
  logic [11:0] ld_adr;
  logic [31:0] ld_wdata;

  logic        m_valid, m_err, m_ld_ack, m_ld_rvalid, m_ovr;
  logic [31:0] m_data, m_ld_rdata;
  logic        a_valid, a_err, a_ld_ack, a_ld_rvalid, a_ovr;
  logic [31:0] a_data, a_ld_rdata;
  logic        b_valid, b_err, b_ld_ack, b_ld_rvalid, b_ovr;
  logic [31:0] b_data, b_ld_rdata;

  evt_t        q_m[$], q_a[$], q_b[$], q_l[$];
  logic [31:0] mdl_mem [0:4095];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  imem_bus_ctrl #(.ADR_W(12), .RD_LAT(LAT_M)) u_m (
    .clk(clk), .rst_n(rst_n), .i_read_req(i_read_req), .i_read_w(i_read_w),
    .i_read_hw(i_read_hw), .i_read_adr(i_read_adr), .i_read_valid(m_valid),
    .i_read_data(m_data), .i_read_err(m_err), .ld_req(ld_req), .ld_we(ld_we),
    .ld_adr(ld_adr), .ld_wdata(ld_wdata), .ld_ack(m_ld_ack), .ld_rvalid(m_ld_rvalid),
    .ld_rdata(m_ld_rdata), .ovr_err(m_ovr));

  imem_bus_ctrl #(.ADR_W(12), .RD_LAT(LAT_A)) u_a (
    .clk(clk), .rst_n(rst_n), .i_read_req(i_read_req), .i_read_w(i_read_w),
    .i_read_hw(i_read_hw), .i_read_adr(i_read_adr), .i_read_valid(a_valid),
    .i_read_data(a_data), .i_read_err(a_err), .ld_req(ld_req), .ld_we(ld_we),
    .ld_adr(ld_adr), .ld_wdata(ld_wdata), .ld_ack(a_ld_ack), .ld_rvalid(a_ld_rvalid),
    .ld_rdata(a_ld_rdata), .ovr_err(a_ovr));

  imem_bus_ctrl #(.ADR_W(12), .RD_LAT(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .i_read_req(i_read_req), .i_read_w(i_read_w),
    .i_read_hw(i_read_hw), .i_read_adr(i_read_adr), .i_read_valid(b_valid),
    .i_read_data(b_data), .i_read_err(b_err), .ld_req(ld_req), .ld_we(ld_we),
    .ld_adr(ld_adr), .ld_wdata(ld_wdata), .ld_ack(b_ld_ack), .ld_rvalid(b_ld_rvalid),
    .ld_rdata(b_ld_rdata), .ovr_err(b_ovr));

  // Record every read-valid pulse with the cycle it appeared in.
  always @(negedge clk) begin : mon
    evt_t ev;
    if (rst_n) begin
      if (m_valid)     begin ev.c = 32'(cyc); ev.d = m_data;     ev.e = m_err; q_m.push_back(ev); end
      if (a_valid)     begin ev.c = 32'(cyc); ev.d = a_data;     ev.e = a_err; q_a.push_back(ev); end
      if (b_valid)     begin ev.c = 32'(cyc); ev.d = b_data;     ev.e = b_err; q_b.push_back(ev); end
      if (m_ld_rvalid) begin ev.c = 32'(cyc); ev.d = m_ld_rdata; ev.e = 1'b0;  q_l.push_back(ev); end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: q_size = q_m.size();
      1: q_size = q_a.size();
      2: q_size = q_b.size();
      default: q_size = q_l.size();
    endcase
  endfunction

  function automatic evt_t q_at(input int k, input int i);
    q_at = '0;
    if (i < q_size(k)) begin
      case (k)
        0: q_at = q_m[i];
        1: q_at = q_a[i];
        2: q_at = q_b[i];
        default: q_at = q_l[i];
      endcase
    end
  endfunction

  task automatic clear_q();
    q_m.delete(); q_a.delete(); q_b.delete(); q_l.delete();
  endtask

  task automatic chk_evt(input string tag, input int k, input int i, input int exp_c,
                         input logic [31:0] exp_d, input logic exp_e);
    evt_t ev;
    ev = q_at(k, i);
    check_eq({tag, ".cyc"}, ev.c, 32'(exp_c));
    check_eq({tag, ".data"}, ev.d, exp_d);
    check_eq({tag, ".err"}, 32'(ev.e), 32'(exp_e));
  endtask

  task automatic chk_one(input string tag, input int k, input int exp_c,
                         input logic [31:0] exp_d, input logic exp_e);
    check_eq({tag, ".count"}, 32'(q_size(k)), 32'd1);
    if (q_size(k) > 0) chk_evt(tag, k, 0, exp_c, exp_d, exp_e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the fetch error rule and returned data.
  function automatic logic exp_err(input logic [31:0] a, input logic w, input logic hw);
    return (a / 32'd4 >= 32'd4096) || (a % 32'd4 != 32'd0) || !w || hw;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a, input logic w, input logic hw);
    if (exp_err(a, w, hw)) return 32'h0;
    return mdl_mem[a / 32'd4];
  endfunction

  task automatic fetch(input logic [31:0] a, input logic w, input logic hw, output int t);
    i_read_req = 1'b1; i_read_adr = a; i_read_w = w; i_read_hw = hw;
    t = cyc;
    tick();
    i_read_req = 1'b0; i_read_w = 1'b1; i_read_hw = 1'b0;
  endtask

  task automatic ld_op(input logic we, input logic [11:0] a, input logic [31:0] d, output int t_acc);
    logic got;
    got = 1'b0;
    t_acc = -1;
    ld_req = 1'b1; ld_we = we; ld_adr = a; ld_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ld_ack) begin got = 1'b1; t_acc = cyc; end
      tick();
      if (got) break;
    end
    ld_req = 1'b0;
    check_eq("ld_ack_seen", 32'(got), 32'd1);
    if (got && we) mdl_mem[a] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, ".valid"},  32'(m_valid), 32'd0);
    check_eq({tag, ".data"},   m_data, 32'h0);
    check_eq({tag, ".err"},    32'(m_err), 32'd0);
    check_eq({tag, ".rvalid"}, 32'(m_ld_rvalid), 32'd0);
    check_eq({tag, ".rdata"},  m_ld_rdata, 32'h0);
    check_eq({tag, ".ovr"},    32'(m_ovr), 32'd0);
  endtask

  initial begin : main
    int t, t1;
    logic [31:0] a, ed;
    logic        w, hw, ee;
    logic [31:0] t3_adr [3];
    int r;

    rst_n = 1'b0;
    i_read_req = 1'b0; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h0;
    ld_req = 1'b0; ld_we = 1'b0; ld_adr = 12'h0; ld_wdata = 32'h0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    check_eq("reset.ld_ack", 32'(m_ld_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: loader preload, uncontended fetch, then back-to-back fetch
    ld_op(1'b1, 12'd0, 32'h00A00093, t);
    ld_op(1'b1, 12'd1, 32'h00000013, t);
    tick();
    clear_q();
    fetch(32'h0, 1'b1, 1'b0, t);
    tick();
    tick();
    fetch(32'h4, 1'b1, 1'b0, t1);
    repeat (6) tick();
    check_eq("t1.count", 32'(q_size(0)), 32'd2);
    chk_evt("t1.first", 0, 0, t + LAT_M, 32'h00A00093, 1'b0);
    chk_evt("t1.b2b", 0, 1, t + 3 + LAT_M, 32'h00000013, 1'b0);
    check_eq("t1.ovr", 32'(m_ovr), 32'd0);

    // 2: fetch and loader read tie; fetch won last, so the loader goes first
    clear_q();
    i_read_req = 1'b1; i_read_adr = 32'h4; ld_req = 1'b1; ld_we = 1'b0; ld_adr = 12'd0;
    t = cyc;
    @(negedge clk);
    check_eq("t2.ld_ack", 32'(m_ld_ack), 32'd1);
    tick();
    i_read_req = 1'b0; ld_req = 1'b0;
    repeat (8) tick();
    chk_one("t2.ld", 3, t + LAT_M, mdl_mem[0], 1'b0);
    chk_one("t2.fetch", 0, t + LAT_M + (LAT_M + 1), mdl_mem[1], 1'b0);

    // 3: misaligned and out-of-range fetches, then a clean one
    t3_adr[0] = 32'h2; t3_adr[1] = 32'h0000_4000; t3_adr[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      clear_q();
      fetch(t3_adr[i], 1'b1, 1'b0, t);
      repeat (5) tick();
      chk_one("t3", 0, t + LAT_M, exp_data(t3_adr[i], 1'b1, 1'b0), exp_err(t3_adr[i], 1'b1, 1'b0));
    end

    // 4: overrun
    clear_q();
    fetch(32'h0, 1'b1, 1'b0, t);
    fetch(32'h4, 1'b1, 1'b0, t1);
    repeat (5) tick();
    chk_one("t4.single", 0, t + LAT_M, mdl_mem[0], 1'b0);
    check_eq("t4.ovr", 32'(m_ovr), 32'd1);
    clear_q();
    fetch(32'h4, 1'b1, 1'b0, t);
    repeat (5) tick();
    chk_one("t4.after", 0, t + LAT_M, mdl_mem[1], 1'b0);
    check_eq("t4.ovr_sticky", 32'(m_ovr), 32'd1);

    // 5: reset while a fetch is in flight
    clear_q();
    fetch(32'h0, 1'b1, 1'b0, t);
    rst_n = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("t5.rst");
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_eq("t5.no_valid", 32'(q_size(0)), 32'd0);
    fetch(32'h0, 1'b1, 1'b0, t);
    repeat (5) tick();
    chk_one("t5.refetch", 0, t + LAT_M, 32'h00A00093, 1'b0);

    // 6: random preload with read-back, then random fetches on all latencies
    repeat (4) tick();
    for (int i = 0; i < 64; i++) begin
      ld_op(1'b1, 12'(i), $urandom, t);
      if (i % 8 == 0) begin
        clear_q();
        ld_op(1'b0, 12'(i), 32'h0, t);
        repeat (6) tick();
        chk_one("raw", 3, t + LAT_M, mdl_mem[i], 1'b0);
      end
    end
    repeat (6) tick();
    clear_q();
    for (int n = 0; n < 100; n++) begin
      r  = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 63)) << 2;
      w  = 1'b1;
      hw = 1'b0;
      case (r)
        7: a = $urandom | 32'h0000_4000;
        8: a = a | 32'($urandom_range(1, 3));
        9: if ($urandom_range(0, 1) == 0) w = 1'b0; else hw = 1'b1;
        default: a = a;
      endcase
      ed = exp_data(a, w, hw);
      ee = exp_err(a, w, hw);
      fetch(a, w, hw, t);
      repeat (6) tick();
      chk_one("rnd.lat2", 0, t + LAT_M, ed, ee);
      chk_one("rnd.lat1", 1, t + LAT_A, ed, ee);
      chk_one("rnd.lat4", 2, t + LAT_B, ed, ee);
      clear_q();
    end
    @(negedge clk);
    check_eq("rnd.ovr1", 32'(a_ovr), 32'd0);
    check_eq("rnd.ovr4", 32'(b_ovr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
